vit_trb_ctrl: RTL

Sequencing controller for the Viterbi traceback decision RAM (2-cycle registered read, 1 write port, 1 read port, clock-enabled). Drives the write side as a circular buffer of ACS decision vectors and launches block tracebacks that read decisions backwards from the newest entry. Produces address/strobe timing aligned with RAM read data for the downstream traceback state unit and bit reorder logic. Sits between the ACS array and the RAM/traceback datapath.

---
 rtl/vit_trb_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/vit_trb_ctrl.sv
// Viterbi traceback decision-RAM sequencer.
// Writes ACS decision vectors into a circular buffer and launches block
// tracebacks that read decisions backwards from the newest entry. Read
// flags are pipelined two enabled cycles so they line up with RAM read data.
module vit_trb_ctrl #(
    parameter int pADDR_W  = 8,
    parameter int pTRB_LEN = 64,
    parameter int pDEC_LEN = 32
) (
    input  logic               iclk,
    input  logic               ireset,
    input  logic               iclkena,
    input  logic               isop,
    input  logic               ival,
    input  logic               ieop,
    output logic               owrite,
    output logic [pADDR_W-1:0] owaddr,
    output logic [pADDR_W-1:0] oraddr,
    output logic               otrb_val,
    output logic               otrb_sot,
    output logic               otrb_dec,
    output logic               otrb_eot,
    output logic               obusy,
    output logic               oerr
);

    // Counter width: one bit wider than the address so lengths never alias.
    localparam int cCW = pADDR_W + 1;

    localparam logic [cCW-1:0]     cLMAX  = cCW'(pTRB_LEN + pDEC_LEN);
    localparam logic [cCW-1:0]     cTRB   = cCW'(pTRB_LEN);
    localparam logic [cCW-1:0]     cDEC   = cCW'(pDEC_LEN);
    localparam logic [cCW-1:0]     cONE   = cCW'(1);
    localparam logic [cCW-1:0]     cZERO  = {cCW{1'b0}};
    localparam logic [pADDR_W-1:0] cA_ONE = pADDR_W'(1);
    localparam logic [pADDR_W-1:0] cA_ZRO = {pADDR_W{1'b0}};

    if ((pTRB_LEN + 2 * pDEC_LEN > 2 ** pADDR_W) || (pDEC_LEN < 1) || (pTRB_LEN < 1)) begin : g_param_check
        $error("vit_trb_ctrl: illegal parameter set");
    end

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_r;
    logic [pADDR_W-1:0] wptr_r;
    logic [pADDR_W-1:0] oraddr_r;
    logic [pADDR_W-1:0] q_start_r;
    logic [cCW-1:0]     fill_r;
    logic [cCW-1:0]     npend_r;
    logic [cCW-1:0]     k_r;
    logic [cCW-1:0]     len_r;
    logic [cCW-1:0]     decb_r;
    logic [cCW-1:0]     q_len_r;
    logic [cCW-1:0]     q_decb_r;
    logic               q_full_r;
    logic               oerr_r;
    logic               p1_val_r;
    logic               p1_sot_r;
    logic               p1_dec_r;
    logic               p1_eot_r;
    logic               p2_val_r;
    logic               p2_sot_r;
    logic               p2_dec_r;
    logic               p2_eot_r;

    logic               wr_s;
    logic               sop_s;
    logic [pADDR_W-1:0] waddr_s;
    logic [cCW-1:0]     fill_base_s;
    logic [cCW-1:0]     fill_nx_s;
    logic [cCW-1:0]     np_base_s;
    logic [cCW-1:0]     np_nx_s;
    logic [cCW-1:0]     trb_n_s;
    logic [cCW-1:0]     len_s;
    logic [cCW-1:0]     decb_s;
    logic               launch_s;
    logic               issue_s;
    logic               last_s;

    // Write address, counter look-ahead including this write, and launch decision.
    // A write always bumps npend to at least 1, so ieop on a write always flushes.
    always_comb begin
        wr_s        = iclkena & ival;
        sop_s       = wr_s & isop;
        waddr_s     = sop_s ? cA_ZRO : wptr_r;
        fill_base_s = sop_s ? cZERO : fill_r;
        fill_nx_s   = (fill_base_s >= cLMAX) ? cLMAX : (fill_base_s + cONE);
        np_base_s   = sop_s ? cZERO : npend_r;
        np_nx_s     = (np_base_s >= cDEC) ? cDEC : (np_base_s + cONE);
        trb_n_s     = cTRB + np_nx_s;
        len_s       = (fill_nx_s < trb_n_s) ? fill_nx_s : trb_n_s;
        decb_s      = len_s - np_nx_s;
        launch_s    = wr_s & (((np_nx_s == cDEC) & (fill_nx_s >= cLMAX)) | ieop);
    end

    // Read issue strobe for this cycle and detection of the final traceback step.
    always_comb begin
        issue_s = (state_r == ST_RUN);
        last_s  = issue_s & (k_r == (len_r - cONE));
    end

    // Write pointer, counters, traceback FSM, one-deep launch queue and flag pipe.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            state_r   <= ST_IDLE;
            wptr_r    <= cA_ZRO;
            oraddr_r  <= cA_ZRO;
            q_start_r <= cA_ZRO;
            fill_r    <= cZERO;
            npend_r   <= cZERO;
            k_r       <= cZERO;
            len_r     <= cZERO;
            decb_r    <= cZERO;
            q_len_r   <= cZERO;
            q_decb_r  <= cZERO;
            q_full_r  <= 1'b0;
            oerr_r    <= 1'b0;
            p1_val_r  <= 1'b0;
            p1_sot_r  <= 1'b0;
            p1_dec_r  <= 1'b0;
            p1_eot_r  <= 1'b0;
            p2_val_r  <= 1'b0;
            p2_sot_r  <= 1'b0;
            p2_dec_r  <= 1'b0;
            p2_eot_r  <= 1'b0;
        end else if (iclkena) begin
            if (wr_s) begin
                wptr_r  <= waddr_s + cA_ONE;
                fill_r  <= fill_nx_s;
                npend_r <= launch_s ? cZERO : np_nx_s;
            end
            // Frame start clears the sticky error; an overflow in the same cycle still sets it below.
            if (sop_s) begin
                oerr_r <= 1'b0;
            end

            p1_val_r <= issue_s;
            p1_sot_r <= issue_s & (k_r == cZERO);
            p1_dec_r <= issue_s & (k_r >= decb_r);
            p1_eot_r <= last_s;
            p2_val_r <= p1_val_r;
            p2_sot_r <= p1_sot_r;
            p2_dec_r <= p1_dec_r;
            p2_eot_r <= p1_eot_r;

            case (state_r)
                ST_IDLE: begin
                    if (launch_s) begin
                        state_r  <= ST_RUN;
                        oraddr_r <= waddr_s;
                        k_r      <= cZERO;
                        len_r    <= len_s;
                        decb_r   <= decb_s;
                    end
                end
                ST_RUN: begin
                    if (last_s) begin
                        if (q_full_r) begin
                            // Queued traceback takes over right after the final read.
                            oraddr_r <= q_start_r;
                            k_r      <= cZERO;
                            len_r    <= q_len_r;
                            decb_r   <= q_decb_r;
                            q_full_r <= 1'b0;
                            if (launch_s) begin
                                oerr_r <= 1'b1;
                            end
                        end else if (launch_s) begin
                            oraddr_r <= waddr_s;
                            k_r      <= cZERO;
                            len_r    <= len_s;
                            decb_r   <= decb_s;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        oraddr_r <= oraddr_r - cA_ONE;
                        k_r      <= k_r + cONE;
                        if (launch_s) begin
                            if (q_full_r) begin
                                oerr_r <= 1'b1;
                            end else begin
                                q_full_r  <= 1'b1;
                                q_start_r <= waddr_s;
                                q_len_r   <= len_s;
                                q_decb_r  <= decb_s;
                            end
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign owrite   = wr_s;
    assign owaddr   = waddr_s;
    assign oraddr   = oraddr_r;
    assign otrb_val = p2_val_r;
    assign otrb_sot = p2_sot_r;
    assign otrb_dec = p2_dec_r;
    assign otrb_eot = p2_eot_r;
    assign obusy    = (state_r == ST_RUN) | q_full_r | p1_val_r | p2_val_r;
    assign oerr     = oerr_r;

endmodule
